// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the pipeline (master) and the memory responder (slave).
// Carries request, write data, read data and the ready/busy/fault status.
interface data_memory_responder_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 20
);
    logic                  req;
    logic                  w;
    logic [ADDR_WIDTH-1:0] daddress;
    logic [DATA_WIDTH-1:0] dout;
    logic [DATA_WIDTH-1:0] datain;
    logic                  ready;
    logic                  busy;
    logic                  fault;

    modport master (
        output req, w, daddress, dout,
        input  datain, ready, busy, fault
    );

    modport slave (
        input  req, w, daddress, dout,
        output datain, ready, busy, fault
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-array responder for the processor data port; optional DMEM_BOUNDS_CHECK_EN flags upper-address faults.
// Latency: ready pulses WAIT_STATES+1 edges after the capture edge; one access per WAIT_STATES+3 cycles.
// Backpressure: busy stays high from capture through the ready cycle; bus inputs are ignored while busy.
module data_memory_responder #(
    parameter int DATA_WIDTH  = 20,
    parameter int ADDR_WIDTH  = 20,
    parameter int ADDR_BITS   = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic rst_n,
    data_memory_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  access;
    logic                  blocked;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  w_q;
    logic [DATA_WIDTH-1:0] datain_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            w_q    <= 1'b0;
        end else if (state_q == IDLE && bus.req) begin
            addr_q <= bus.daddress[ADDR_BITS-1:0];
            data_q <= bus.dout;
            w_q    <= bus.w;
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    logic oob_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_q <= 1'b0;
        end else if (state_q == IDLE && bus.req) begin
            oob_q <= |bus.daddress[ADDR_WIDTH-1:ADDR_BITS];
        end
    end

    assign blocked   = oob_q;
    assign bus.fault = (state_q == DONE) && oob_q;
`else
    // Upper address bits alias onto the array when bounds checking is off.
    logic unused_upper;
    assign unused_upper = |bus.daddress[ADDR_WIDTH-1:ADDR_BITS];
    assign blocked      = 1'b0;
    assign bus.fault    = 1'b0;
`endif

    // The array is not reset; access is gated by state_q, so an async reset cancels a pending write.
    always_ff @(posedge clk) begin
        if (access && w_q && !blocked) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            datain_q <= '0;
        end else if (access && blocked) begin
            datain_q <= '0;
        end else if (access && !w_q) begin
            datain_q <= mem[addr_q];
        end
    end

    assign bus.datain = datain_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.ready  = (state_q == DONE);
endmodule
